// File: rtl/reg_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// reg_hazard_ctrl
//
// Issue-stage interlock and forwarding controller for a 5-stage MIPS pipeline.
// The destination register of every issued instruction is carried through
// shadow EX/MEM/WB registers. Each cycle, the ID-stage sources are compared
// against those shadows. The comparison decides two things:
//   - whether the ID instruction must stall, and
//   - which forwarding select the instruction will use once it sits in EX.
// Stall cycles are counted in a saturating counter for performance inspection.
//
// Parameters
//   FWD_EN         1: forward from MEM/WB results; 0: interlock until the
//                  producer has left the pipeline (no forwarding)
//   REGFILE_BYPASS 1: register file is write-before-read, WB producer is free
//                  0: a WB-stage producer also stalls the consumer
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   id_valid          ID holds a real instruction
//   id_rs, id_rt      source register numbers
//   id_use_rs/rt      instruction actually reads rs / rt
//   id_dest           destination register (0 = no write)
//   id_is_load        instruction is a load (LB/LBU/LW)
//   flush             taken branch/jump, kills the ID instruction
//   stall             combinational: hold PC and IF/ID, bubble into EX
//   fwd_rs_sel/rt_sel EX operand source: 0 regfile, 1 MEM result, 2 WB result
//   ex/mem/wb_dest    shadow destination registers
//   stall_cnt         saturating count of stall cycles
// -----------------------------------------------------------------------------
module reg_hazard_ctrl #(
  parameter bit FWD_EN         = 1'b1,
  parameter bit REGFILE_BYPASS = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_use_rs,
  input  logic        id_use_rt,
  input  logic [4:0]  id_dest,
  input  logic        id_is_load,
  input  logic        flush,
  output logic        stall,
  output logic [1:0]  fwd_rs_sel,
  output logic [1:0]  fwd_rt_sel,
  output logic [4:0]  ex_dest,
  output logic [4:0]  mem_dest,
  output logic [4:0]  wb_dest,
  output logic [31:0] stall_cnt
);

  localparam logic [1:0]  SEL_RF  = 2'd0;
  localparam logic [1:0]  SEL_MEM = 2'd1;
  localparam logic [1:0]  SEL_WB  = 2'd2;
  localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

  logic [4:0]  ex_dest_q, ex_dest_d;
  logic [4:0]  mem_dest_q, mem_dest_d;
  logic [4:0]  wb_dest_q, wb_dest_d;
  logic        ex_is_load_q, ex_is_load_d;
  logic [1:0]  fwd_rs_sel_q, fwd_rs_sel_d;
  logic [1:0]  fwd_rt_sel_q, fwd_rt_sel_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  logic hit_ex_s;
  logic hit_mem_s;
  logic hit_wb_s;
  logic wb_term_s;
  logic hz_s;
  logic stall_s;
  logic issue_s;

  // A source hazards against a destination only if it is really read and is
  // not register 0 (writes to r0 are discarded, so r0 never carries a value).
  function automatic logic src_match(input logic use_src, input logic [4:0] src,
                                     input logic [4:0] dest);
    return use_src && (src != 5'd0) && (src == dest);
  endfunction

  // Forward select for one operand, evaluated at issue time. The producer
  // now in EX will be in MEM when the consumer is in EX, so it is forwarded
  // from the MEM result. The producer now in MEM will be in WB, so it is
  // forwarded from the WB result. The younger (EX) producer wins.
  function automatic logic [1:0] fwd_pick(input logic use_src, input logic [4:0] src,
                                          input logic [4:0] ex_d, input logic [4:0] mem_d);
    logic [1:0] sel;
    if (src_match(use_src, src, ex_d)) begin
      sel = SEL_MEM;
    end else if (src_match(use_src, src, mem_d)) begin
      sel = SEL_WB;
    end else begin
      sel = SEL_RF;
    end
    return sel;
  endfunction

  // Hazard detection and stall decision for the instruction in ID.
  always_comb begin
    hit_ex_s  = src_match(id_use_rs, id_rs, ex_dest_q)  || src_match(id_use_rt, id_rt, ex_dest_q);
    hit_mem_s = src_match(id_use_rs, id_rs, mem_dest_q) || src_match(id_use_rt, id_rt, mem_dest_q);
    hit_wb_s  = src_match(id_use_rs, id_rs, wb_dest_q)  || src_match(id_use_rt, id_rt, wb_dest_q);
    wb_term_s = REGFILE_BYPASS ? 1'b0 : hit_wb_s;
    hz_s      = 1'b0;
    if (FWD_EN) begin
      // Only a load in EX cannot be forwarded in time.
      hz_s = (hit_ex_s && ex_is_load_q) || wb_term_s;
    end else begin
      hz_s = hit_ex_s || hit_mem_s || wb_term_s;
    end
    // Flush kills the ID instruction, so it never stalls.
    stall_s = id_valid && !flush && hz_s;
    issue_s = id_valid && !flush && !hz_s;
  end

  // Next-state computation for the shadow pipeline, selects and counter.
  always_comb begin
    mem_dest_d   = ex_dest_q;
    wb_dest_d    = mem_dest_q;
    ex_dest_d    = 5'd0;
    ex_is_load_d = 1'b0;
    fwd_rs_sel_d = SEL_RF;
    fwd_rt_sel_d = SEL_RF;
    stall_cnt_d  = stall_cnt_q;

    if (issue_s) begin
      ex_dest_d    = id_dest;
      ex_is_load_d = id_is_load;
    end else begin
      ex_dest_d    = 5'd0;
      ex_is_load_d = 1'b0;
    end

    if (issue_s && FWD_EN) begin
      fwd_rs_sel_d = fwd_pick(id_use_rs, id_rs, ex_dest_q, mem_dest_q);
      fwd_rt_sel_d = fwd_pick(id_use_rt, id_rt, ex_dest_q, mem_dest_q);
    end else begin
      fwd_rs_sel_d = SEL_RF;
      fwd_rt_sel_d = SEL_RF;
    end

    if (stall_s && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // State registers; reset empties the pipeline and forgets all producers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_dest_q    <= 5'd0;
      mem_dest_q   <= 5'd0;
      wb_dest_q    <= 5'd0;
      ex_is_load_q <= 1'b0;
      fwd_rs_sel_q <= SEL_RF;
      fwd_rt_sel_q <= SEL_RF;
      stall_cnt_q  <= 32'd0;
    end else begin
      ex_dest_q    <= ex_dest_d;
      mem_dest_q   <= mem_dest_d;
      wb_dest_q    <= wb_dest_d;
      ex_is_load_q <= ex_is_load_d;
      fwd_rs_sel_q <= fwd_rs_sel_d;
      fwd_rt_sel_q <= fwd_rt_sel_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign stall      = stall_s;
  assign fwd_rs_sel = fwd_rs_sel_q;
  assign fwd_rt_sel = fwd_rt_sel_q;
  assign ex_dest    = ex_dest_q;
  assign mem_dest   = mem_dest_q;
  assign wb_dest    = wb_dest_q;
  assign stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_reg_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_reg_hazard_ctrl
//
// Three instances share the ID-stage inputs:
//   dut  : FWD_EN=1, REGFILE_BYPASS=1 (table-driven vectors)
//   dut0 : FWD_EN=0, REGFILE_BYPASS=0
//   dut1 : FWD_EN=0, REGFILE_BYPASS=1
// Each vector carries its expected values. Registered expectations are queued
// when the stimulus is driven, then popped and compared after the clock edge.
// -----------------------------------------------------------------------------
module tb_reg_hazard_ctrl;

  logic        clk;
  logic        rst_n;
  logic        id_valid;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        id_use_rs;
  logic        id_use_rt;
  logic [4:0]  id_dest;
  logic        id_is_load;
  logic        flush;

  logic        o_stall,  o0_stall,  o1_stall;
  logic [1:0]  o_rs_sel, o0_rs_sel, o1_rs_sel;
  logic [1:0]  o_rt_sel, o0_rt_sel, o1_rt_sel;
  logic [4:0]  o_ex,     o0_ex,     o1_ex;
  logic [4:0]  o_mem,    o0_mem,    o1_mem;
  logic [4:0]  o_wb,     o0_wb,     o1_wb;
  logic [31:0] o_cnt,    o0_cnt,    o1_cnt;

  int total;
  int bad;

  reg_hazard_ctrl #(.FWD_EN(1'b1), .REGFILE_BYPASS(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_dest(id_dest),
    .id_is_load(id_is_load), .flush(flush), .stall(o_stall),
    .fwd_rs_sel(o_rs_sel), .fwd_rt_sel(o_rt_sel), .ex_dest(o_ex),
    .mem_dest(o_mem), .wb_dest(o_wb), .stall_cnt(o_cnt));

  reg_hazard_ctrl #(.FWD_EN(1'b0), .REGFILE_BYPASS(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_dest(id_dest),
    .id_is_load(id_is_load), .flush(flush), .stall(o0_stall),
    .fwd_rs_sel(o0_rs_sel), .fwd_rt_sel(o0_rt_sel), .ex_dest(o0_ex),
    .mem_dest(o0_mem), .wb_dest(o0_wb), .stall_cnt(o0_cnt));

  reg_hazard_ctrl #(.FWD_EN(1'b0), .REGFILE_BYPASS(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_dest(id_dest),
    .id_is_load(id_is_load), .flush(flush), .stall(o1_stall),
    .fwd_rs_sel(o1_rs_sel), .fwd_rt_sel(o1_rt_sel), .ex_dest(o1_ex),
    .mem_dest(o1_mem), .wb_dest(o1_wb), .stall_cnt(o1_cnt));

  // Free-running clock, posedge at 5, 15, 25 ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst_before;
    logic        valid;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic        use_rs;
    logic        use_rt;
    logic [4:0]  dest;
    logic        ld;
    logic        fl;
    logic        exp_stall;
    logic [1:0]  exp_rs;
    logic [1:0]  exp_rt;
    logic [4:0]  exp_ex;
    logic [31:0] exp_cnt;
  } vec_t;

  typedef struct {
    int          idx;
    logic [1:0]  rs;
    logic [1:0]  rt;
    logic [4:0]  ex;
    logic [31:0] cnt;
  } exp_t;

  vec_t        vecs[20];
  exp_t        sb[$];
  logic [31:0] cnt_sb[$];

  function automatic vec_t mk(input logic rb, input logic v, input logic [4:0] rs,
                              input logic [4:0] rt, input logic urs, input logic urt,
                              input logic [4:0] d, input logic ld, input logic fl,
                              input logic es, input logic [1:0] ers, input logic [1:0] ert,
                              input logic [4:0] eex, input logic [31:0] ec);
    vec_t r;
    r.rst_before = rb; r.valid = v; r.rs = rs; r.rt = rt; r.use_rs = urs; r.use_rt = urt;
    r.dest = d; r.ld = ld; r.fl = fl; r.exp_stall = es; r.exp_rs = ers; r.exp_rt = ert;
    r.exp_ex = eex; r.exp_cnt = ec;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic urs, input logic urt, input logic [4:0] d,
                       input logic ld, input logic fl);
    id_valid = v; id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
    id_dest = d; id_is_load = ld; flush = fl;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  // Full reset pulse, entered and left just after a negedge.
  task automatic reset_pulse();
    idle();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // One cycle of the main instance: called just after a negedge.
  task automatic apply(input int idx, input vec_t v);
    exp_t e;
    exp_t got;
    if (v.rst_before) begin
      drive(v.valid, v.rs, v.rt, v.use_rs, v.use_rt, v.dest, v.ld, v.fl);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_stall", {31'd0, o_stall}, 32'd0);
      chk("midrst_ex",    {27'd0, o_ex},    32'd0);
      chk("midrst_mem",   {27'd0, o_mem},   32'd0);
      chk("midrst_wb",    {27'd0, o_wb},    32'd0);
      chk("midrst_sel",   {28'd0, o_rs_sel, o_rt_sel}, 32'd0);
      chk("midrst_cnt",   o_cnt,            32'd0);
      @(negedge clk);
      rst_n = 1'b1;
    end
    drive(v.valid, v.rs, v.rt, v.use_rs, v.use_rt, v.dest, v.ld, v.fl);
    #1;
    chk($sformatf("v%0d_stall", idx), {31'd0, o_stall}, {31'd0, v.exp_stall});
    e.idx = idx; e.rs = v.exp_rs; e.rt = v.exp_rt; e.ex = v.exp_ex; e.cnt = v.exp_cnt;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk("sb_underflow", 32'd0, 32'd1);
    end else begin
      got = sb.pop_front();
      chk($sformatf("v%0d_rs_sel", got.idx), {30'd0, o_rs_sel}, {30'd0, got.rs});
      chk($sformatf("v%0d_rt_sel", got.idx), {30'd0, o_rt_sel}, {30'd0, got.rt});
      chk($sformatf("v%0d_ex", got.idx),     {27'd0, o_ex},     {27'd0, got.ex});
      chk($sformatf("v%0d_cnt", got.idx),    o_cnt,             got.cnt);
    end
    @(negedge clk);
  endtask

  int  n0;
  int  n1;
  logic done;

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b1;
    idle();

    // Table: rst_before, valid, rs, rt, use_rs, use_rt, dest, load, flush,
    //        exp stall, exp rs_sel, exp rt_sel, exp ex_dest, exp stall_cnt
    vecs[0]  = mk(0,1, 0, 0,1,0, 8,0,0, 0,0,0, 8,0);  // addi r8
    vecs[1]  = mk(0,1, 8, 9,1,1,10,0,0, 0,1,0,10,0);  // add r8,r9: ALU forward
    vecs[2]  = mk(0,1, 9, 8,1,1,11,0,0, 0,0,2,11,0);  // r8 two slots later: WB
    vecs[3]  = mk(0,1,11, 0,1,0, 5,1,0, 0,1,0, 5,0);  // lw r5
    vecs[4]  = mk(0,1, 5, 0,1,1, 6,0,0, 1,0,0, 0,1);  // load-use stall
    vecs[5]  = mk(0,1, 5, 0,1,1, 6,0,0, 0,2,0, 6,1);  // issues, WB forward
    vecs[6]  = mk(0,1, 0, 0,1,0, 0,1,0, 0,0,0, 0,1);  // lw r0
    vecs[7]  = mk(0,1, 0, 0,1,1,12,0,0, 0,0,0,12,1);  // reads r0: no hazard
    vecs[8]  = mk(0,1, 0, 0,0,0, 7,0,0, 0,0,0, 7,1);  // producer r7
    vecs[9]  = mk(0,1, 0, 0,0,0, 7,0,0, 0,0,0, 7,1);  // producer r7 again
    vecs[10] = mk(0,1, 1, 7,1,1,13,0,0, 0,0,1,13,1);  // EX producer wins
    vecs[11] = mk(0,1, 0, 0,0,0, 4,1,0, 0,0,0, 4,1);  // lw r4
    vecs[12] = mk(0,1, 4, 0,1,0,14,0,1, 0,0,0, 0,1);  // load-use + flush
    vecs[13] = mk(0,0, 4, 0,1,0,15,0,0, 0,0,0, 0,1);  // invalid ID: bubble
    vecs[14] = mk(0,1, 0, 0,0,0,20,1,0, 0,0,0,20,1);  // lw r20
    vecs[15] = mk(0,1,20,20,1,1,21,0,0, 1,0,0, 0,2);  // both sources stall
    vecs[16] = mk(0,1,20,20,1,1,21,0,0, 0,2,2,21,2);  // both forward from WB
    vecs[17] = mk(0,1, 0, 0,0,0, 9,1,0, 0,0,0, 9,2);  // lw r9 then reset
    vecs[18] = mk(1,1, 9, 0,1,0,10,0,0, 0,0,0,10,0);  // forgotten producer
    vecs[19] = mk(0,1,10, 0,1,0,11,0,0, 0,1,0,11,0);  // dependent pair after reset

    // Asynchronous reset from power-up: outputs zero without any clock edge.
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_stall", {29'd0, o_stall, o0_stall, o1_stall}, 32'd0);
    chk("rst_dests", {17'd0, o_ex, o_mem, o_wb}, 32'd0);
    chk("rst_sels",  {28'd0, o_rs_sel, o_rt_sel}, 32'd0);
    chk("rst_cnt",   o_cnt | o0_cnt | o1_cnt, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      apply(i, vecs[i]);
      if (i == 16) begin
        chk("pipe_mem", {27'd0, o_mem}, 32'd0);
        chk("pipe_wb",  {27'd0, o_wb},  32'd20);
      end
    end

    // No forwarding: addi r3 then consumer of r3, held in ID while stalled.
    reset_pulse();
    drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd3, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b1, 5'd3, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
    n0 = 0;
    n1 = 0;
    done = 1'b0;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (o0_stall) n0++;
      if (o1_stall) n1++;
      done = !o0_stall;
      @(posedge clk);
      #1;
      chk("nofwd_rs_sel", {30'd0, o0_rs_sel}, 32'd0);
      if (!done) chk("nofwd_bubble", {27'd0, o0_ex}, 32'd0);
      @(negedge clk);
      if (done) break;
    end
    chk("nofwd_nobyp_stalls", n0, 32'd3);
    chk("nofwd_byp_stalls",   n1, 32'd2);
    chk("nofwd_nobyp_cnt",    o0_cnt, 32'd3);
    chk("nofwd_byp_cnt",      o1_cnt, 32'd2);
    idle();

    // Counter saturation on the no-forwarding instance.
    reset_pulse();
    force dut0.stall_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut0.stall_cnt_q;
    chk("sat_preset", o0_cnt, 32'hFFFF_FFFE);
    drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd3, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b1, 5'd3, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("sat_stall", {31'd0, o0_stall}, 32'd1);
      cnt_sb.push_back(32'hFFFF_FFFF);
      @(posedge clk);
      #1;
      if (cnt_sb.size() != 0) chk("sat_cnt", o0_cnt, cnt_sb.pop_front());
      @(negedge clk);
    end
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #20000;
    $display("FAIL timeout: actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
